// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
// SAT_MAX/SAT_MIN are only referenced when CLA_SAT_EN is defined.
package cla_pkg;

    localparam int CLA_SEG_DEFAULT = 8;
    localparam int SAT_W_MAX       = 1024;

    function automatic int cla_stages(input int n, input int seg);
        int r;
        if (seg > 0) begin
            r = n / seg;
        end else begin
            r = 0;
        end
        return r;
    endfunction

    // Largest positive two's-complement value of width n, zero-extended to SAT_W_MAX.
    function automatic logic [SAT_W_MAX-1:0] SAT_MAX(input int n);
        logic [SAT_W_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_W_MAX; i++) begin
            if (i < n - 1) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    function automatic logic [SAT_W_MAX-1:0] SAT_MIN(input int n);
        logic [SAT_W_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_W_MAX; i++) begin
            if (i == n - 1) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead slice. c_msb_in is the carry entering the
// top bit, which the last pipeline stage needs for signed overflow.
module cla_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           c_msb_in
);

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Lookahead recurrence C[i+1] = G | P&C[i], flattened by synthesis inside the slice.
    always_comb begin : p_carry
        logic [SEG:0] c;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = w_g[i] | (w_p[i] & c[i]);
        end
        s        = w_p ^ c[SEG-1:0];
        cout     = c[SEG];
        c_msb_in = c[SEG-1];
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined N-bit carry-lookahead adder/subtractor, one SEG-bit slice per stage,
// global-stall valid/ready flow control. Optional macro CLA_SAT_EN adds signed saturation.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int N   = 32,
    parameter int SEG = CLA_SEG_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int STAGES = cla_stages(N, SEG);

    if (SEG < 1) begin : g_chk_seg
        $error("pipelined_cla_addsub: SEG must be at least 1");
    end else if ((N % SEG) != 0) begin : g_chk_div
        $error("pipelined_cla_addsub: N must be a multiple of SEG");
    end

    logic [N-1:0]   w_bx;
    logic           w_c0;
    logic           w_adv;

    logic           r_out_valid;
    logic [N-1:0]   r_sum;
    logic           r_cout;
    logic           r_ovf;

    assign w_bx     = sub ? ~b : b;
    assign w_c0     = sub ? 1'b1 : cin;
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv;

    // Stages 0..STAGES-2: r_a_hi/r_b_hi carry the unprocessed slices, r_lo the finished sum.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_pipe
        localparam int LW = (k + 1) * SEG;
        localparam int HW = N - LW;

        logic [SEG-1:0] w_sa;
        logic [SEG-1:0] w_sb;
        logic [SEG-1:0] w_s;
        logic           w_ci;
        logic           w_co;
        logic           w_unused_cm;
        logic           w_vi;
        logic [HW-1:0]  w_a_hi;
        logic [HW-1:0]  w_b_hi;
        logic [LW-1:0]  w_lo;

        logic           r_v;
        logic           r_c;
        logic [HW-1:0]  r_a_hi;
        logic [HW-1:0]  r_b_hi;
        logic [LW-1:0]  r_lo;

        if (k == 0) begin : g_src
            assign w_sa   = a[SEG-1:0];
            assign w_sb   = w_bx[SEG-1:0];
            assign w_ci   = w_c0;
            assign w_vi   = in_valid;
            assign w_a_hi = a[N-1:SEG];
            assign w_b_hi = w_bx[N-1:SEG];
            assign w_lo   = w_s;
        end else begin : g_src
            assign w_sa   = g_pipe[k-1].r_a_hi[SEG-1:0];
            assign w_sb   = g_pipe[k-1].r_b_hi[SEG-1:0];
            assign w_ci   = g_pipe[k-1].r_c;
            assign w_vi   = g_pipe[k-1].r_v;
            assign w_a_hi = g_pipe[k-1].r_a_hi[HW+SEG-1:SEG];
            assign w_b_hi = g_pipe[k-1].r_b_hi[HW+SEG-1:SEG];
            assign w_lo   = {w_s, g_pipe[k-1].r_lo};
        end

        cla_segment #(.SEG(SEG)) u_seg (
            .a        (w_sa),
            .b        (w_sb),
            .cin      (w_ci),
            .s        (w_s),
            .cout     (w_co),
            .c_msb_in (w_unused_cm)
        );

        // Stage register; bubbles shift like real beats, everything freezes on stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v    <= 1'b0;
                r_c    <= 1'b0;
                r_a_hi <= '0;
                r_b_hi <= '0;
                r_lo   <= '0;
            end else if (w_adv) begin
                r_v    <= w_vi;
                r_c    <= w_co;
                r_a_hi <= w_a_hi;
                r_b_hi <= w_b_hi;
                r_lo   <= w_lo;
            end
        end
    end

    logic [SEG-1:0] w_fa;
    logic [SEG-1:0] w_fb;
    logic [SEG-1:0] w_fs;
    logic           w_fci;
    logic           w_fco;
    logic           w_fcm;
    logic           w_fvi;
    logic           w_fovf;
    logic [N-1:0]   w_fres;
    logic [N-1:0]   w_fout;

    if (STAGES == 1) begin : g_last_src
        assign w_fa   = a;
        assign w_fb   = w_bx;
        assign w_fci  = w_c0;
        assign w_fvi  = in_valid;
        assign w_fres = w_fs;
    end else begin : g_last_src
        assign w_fa   = g_pipe[STAGES-2].r_a_hi;
        assign w_fb   = g_pipe[STAGES-2].r_b_hi;
        assign w_fci  = g_pipe[STAGES-2].r_c;
        assign w_fvi  = g_pipe[STAGES-2].r_v;
        assign w_fres = {w_fs, g_pipe[STAGES-2].r_lo};
    end

    cla_segment #(.SEG(SEG)) u_seg_last (
        .a        (w_fa),
        .b        (w_fb),
        .cin      (w_fci),
        .s        (w_fs),
        .cout     (w_fco),
        .c_msb_in (w_fcm)
    );

    assign w_fovf = w_fcm ^ w_fco;

`ifdef CLA_SAT_EN
    localparam logic [SAT_W_MAX-1:0] SAT_HI = SAT_MAX(N);
    localparam logic [SAT_W_MAX-1:0] SAT_LO = SAT_MIN(N);

    // On overflow both operand MSBs agree, so a's MSB alone selects the clamp direction.
    always_comb begin
        if (w_fovf) begin
            if (w_fa[SEG-1]) begin
                w_fout = SAT_LO[N-1:0];
            end else begin
                w_fout = SAT_HI[N-1:0];
            end
        end else begin
            w_fout = w_fres;
        end
    end
`else
    assign w_fout = w_fres;
`endif

    // Output register: the only point where a finished beat waits for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_fvi;
            r_sum       <= w_fout;
            r_cout      <= w_fco;
            r_ovf       <= w_fovf;
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (N=32, SEG=8): directed vectors with
// hand-computed results, pushed on acceptance and popped by an independent monitor.
module tb_pipelined_cla_addsub;

    localparam int N   = 32;
    localparam int LAT = 4;

`ifdef CLA_SAT_EN
    localparam logic [N-1:0] E_POS_OVF  = 32'h7FFF_FFFF;
    localparam logic [N-1:0] E_NEG_ADD  = 32'h8000_0000;
    localparam logic [N-1:0] E_NEG_SUB  = 32'h8000_0000;
    localparam logic [N-1:0] E_POS_SUB  = 32'h7FFF_FFFF;
`else
    localparam logic [N-1:0] E_POS_OVF  = 32'h8000_0000;
    localparam logic [N-1:0] E_NEG_ADD  = 32'h0000_0000;
    localparam logic [N-1:0] E_NEG_SUB  = 32'h7FFF_FFFF;
    localparam logic [N-1:0] E_POS_SUB  = 32'h8000_0000;
`endif

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [N-1:0] s;
        logic         co;
        logic         ov;
        int           cyc;
        bit           chk;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp     = 0;
    int           n_fail    = 0;
    int           cyc       = 0;
    bit           rdy_mode  = 1'b0;
    int           rdy_idx   = 0;
    logic         stall_q   = 1'b0;
    logic [N-1:0] sum_q     = '0;
    logic         co_q      = 1'b0;
    logic         ov_q      = 1'b0;

    pipelined_cla_addsub #(.N(N), .SEG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // out_ready: constant 1, or the repeating 1,0,0,1 pattern while rdy_mode is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                out_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
                rdy_idx++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: handshake rule, stall stability and in-order result checking.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
            end else begin
                check("in_ready_rule", {63'd0, in_ready}, {63'd0, ~(out_valid & ~out_ready)});
                if (stall_q) begin
                    check("stall_hold", {29'd0, out_valid, sum, cout, ovf},
                          {29'd0, 1'b1, sum_q, co_q, ov_q});
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_out: actual sum=0x%0h required no output", sum);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", {30'd0, sum, cout, ovf}, {30'd0, e.s, e.co, e.ov});
                        if (e.chk) begin
                            check("latency", 64'(cyc - e.cyc), 64'(LAT));
                        end
                    end
                end
                stall_q = out_valid & ~out_ready;
                sum_q   = sum;
                co_q    = cout;
                ov_q    = ovf;
            end
        end
    end

    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                        input logic ts, input logic [N-1:0] es, input logic eco,
                        input logic eov, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        a        = ta;
        b        = tb;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        #1;
        for (int w = 0; w < 64 && in_ready !== 1'b1; w++) begin
            @(posedge clk);
            #2;
        end
        check("accept", {63'd0, in_ready}, 64'd1);
        if (in_ready === 1'b1) begin
            e.s   = es;
            e.co  = eco;
            e.ov  = eov;
            e.cyc = cyc;
            e.chk = chk;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 200 && sb_q.size() != 0; w++) begin
            @(posedge clk);
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", {32'd0, sum}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
        repeat (6) idle();
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, E_POS_OVF,     1'b0, 1'b1, 1'b1);
        idle();
        drain();

        rdy_mode = 1'b1;
        send(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, E_NEG_ADD,     1'b1, 1'b1, 1'b0);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, E_NEG_SUB,     1'b1, 1'b1, 1'b0);
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        send(32'h00FF_00FF, 32'h0101_0101, 1'b0, 1'b0, 32'h0200_0200, 1'b0, 1'b0, 1'b0);
        send(32'h4000_0000, 32'hC000_0000, 1'b0, 1'b1, E_POS_SUB,     1'b0, 1'b1, 1'b0);
        idle();
        drain();
        rdy_mode = 1'b0;
        repeat (2) idle();

        send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
        send(32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 32'h0000_3000, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2;
            check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        end
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b1);
        idle();
        drain();
        repeat (6) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
